// File: rtl/tone_seq_pkg.sv
// Shared types and constants for the tone bus sequencer: command encoding,
// register map helpers, FSM states and the command FIFO entry layout.
package tone_seq_pkg;

  localparam logic CMD_PERIOD = 1'b0;
  localparam logic CMD_ENABLE = 1'b1;

  localparam logic [3:0] ADDR_ENABLE = 4'd15;
  localparam int         NUM_VOICES  = 3;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    AGAP,
    DATA,
    DGAP
  } seqState_t;

  typedef struct packed {
    logic        cmdType;
    logic [1:0]  voice;
    logic [11:0] data;
  } fifoEntry_t;

  // Each voice owns three consecutive nibble registers starting at 1+3v.
  function automatic logic [3:0] voiceBase(input logic [1:0] voice);
    return 4'd1 + 4'd3 * {2'b00, voice};
  endfunction

endpackage

// File: rtl/tone_seq_fifo.sv
// Synchronous command FIFO for the tone bus sequencer; first-word fall-through
// read port so the sequencer sees the head entry in the cycle it pops it.
module tone_seq_fifo
  import tone_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  fifoEntry_t pushData,
  input  logic       pop,
  output fifoEntry_t popData,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  fifoEntry_t      mem [FIFO_DEPTH];
  logic [AW:0]     wrPtr;
  logic [AW:0]     rdPtr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push && !full)
        wrPtr <= wrPtr + {{AW{1'b0}}, 1'b1};
      if (pop && !empty)
        rdPtr <= rdPtr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wrPtr[AW-1:0]] <= pushData;
  end

  assign empty   = (wrPtr == rdPtr);
  assign full    = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign popData = mem[rdPtr[AW-1:0]];

endmodule

// File: rtl/tone_bus_sequencer.sv
// Expands buffered period/enable commands into address and data nibble strobes
// on the tone core write bus. Optional macro: TONE_SEQ_SKIP_UNCHANGED_EN.
module tone_bus_sequencer
  import tone_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WR_IDLE    = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_type,
  input  logic [1:0]  cmd_voice,
  input  logic [11:0] cmd_data,
  output logic        busy,
  output logic        err,
  output logic        A0,
  output logic        WR,
  output logic [3:0]  D
);

  localparam bit         HAS_GAP  = (WR_IDLE > 0);
  localparam logic [2:0] GAP_LOAD = 3'(WR_IDLE > 0 ? WR_IDLE - 1 : 0);

  seqState_t  state, nextState;
  fifoEntry_t pushEntry, popEntry, curCmd;
  logic       fifoFull, fifoEmpty, fifoPush, fifoPop, loadCmd;
  logic       cmdAccept, cmdInvalid;
  logic [1:0] nibIdx, nextIdx, effIdx;
  logic [2:0] gapCnt, nextGap;
  logic [2:0] needMask;
  logic       found, moreAfter;

  function automatic logic [3:0] nibbleOf(input fifoEntry_t c, input logic [1:0] idx);
    if (c.cmdType == CMD_ENABLE)
      return {1'b0, c.data[2:0]};
    case (idx)
      2'd0:    return c.data[3:0];
      2'd1:    return c.data[7:4];
      default: return c.data[11:8];
    endcase
  endfunction

  function automatic logic [3:0] addrOf(input fifoEntry_t c, input logic [1:0] idx);
    if (c.cmdType == CMD_ENABLE)
      return ADDR_ENABLE;
    return voiceBase(c.voice) + {2'b00, idx};
  endfunction

  assign cmd_ready  = !fifoFull && !RST;
  assign cmdAccept  = cmd_valid && cmd_ready;
  assign cmdInvalid = (cmd_type == CMD_PERIOD) && (cmd_voice == 2'd3);
  assign fifoPush   = cmdAccept && !cmdInvalid;
  assign pushEntry  = '{cmdType: cmd_type, voice: cmd_voice, data: cmd_data};
  assign busy       = !fifoEmpty || (state != IDLE);

  tone_seq_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) cmdFifo (
    .clk      (CLK),
    .rst      (RST),
    .push     (fifoPush),
    .pushData (pushEntry),
    .pop      (fifoPop),
    .popData  (popEntry),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

`ifdef TONE_SEQ_SKIP_UNCHANGED_EN
  logic [3:0]              shNib [3*NUM_VOICES];
  logic [3*NUM_VOICES-1:0] shValid;
  logic [2:0]              enShadow;
  logic                    enValid;

  function automatic logic [3:0] slotOf(input logic [1:0] voice, input logic [1:0] idx);
    return {2'b00, voice} * 4'd3 + {2'b00, idx};
  endfunction

  // A nibble needs writing unless the core is already known to hold that value.
  always_comb begin
    needMask = '0;
    if (curCmd.cmdType == CMD_ENABLE)
      needMask[2] = !(enValid && (enShadow == curCmd.data[2:0]));
    else
      for (int i = 0; i < 3; i++)
        needMask[i] = !(shValid[slotOf(curCmd.voice, 2'(i))] &&
                        (shNib[slotOf(curCmd.voice, 2'(i))] == nibbleOf(curCmd, 2'(i))));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      shValid <= '0;
      enValid <= 1'b0;
    end else if (state == DATA) begin
      if (curCmd.cmdType == CMD_ENABLE)
        enValid <= 1'b1;
      else
        shValid[slotOf(curCmd.voice, nibIdx)] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (state == DATA) begin
      if (curCmd.cmdType == CMD_ENABLE)
        enShadow <= curCmd.data[2:0];
      else
        shNib[slotOf(curCmd.voice, nibIdx)] <= nibbleOf(curCmd, nibIdx);
    end
  end
`else
  assign needMask = 3'b111;
`endif

  // Lowest nibble at or after the current index that still has to go out.
  always_comb begin
    found     = 1'b0;
    effIdx    = nibIdx;
    moreAfter = 1'b0;
    for (int i = 2; i >= 0; i--) begin
      if ((2'(i) >= nibIdx) && needMask[i]) begin
        found  = 1'b1;
        effIdx = 2'(i);
      end
      if ((2'(i) > nibIdx) && needMask[i])
        moreAfter = 1'b1;
    end
  end

  always_comb begin
    nextState = state;
    nextIdx   = nibIdx;
    nextGap   = gapCnt;
    fifoPop   = 1'b0;
    loadCmd   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifoEmpty) begin
          fifoPop   = 1'b1;
          loadCmd   = 1'b1;
          nextIdx   = (popEntry.cmdType == CMD_ENABLE) ? 2'd2 : 2'd0;
          nextState = ADDR;
        end
      end
      ADDR: begin
        if (!found) begin
          nextState = IDLE;
        end else begin
          nextIdx = effIdx;
          if (HAS_GAP) begin
            nextState = AGAP;
            nextGap   = GAP_LOAD;
          end else begin
            nextState = DATA;
          end
        end
      end
      AGAP: begin
        if (gapCnt == 3'd0)
          nextState = DATA;
        else
          nextGap = gapCnt - 3'd1;
      end
      DATA: begin
        if (HAS_GAP) begin
          nextState = DGAP;
          nextGap   = GAP_LOAD;
        end else if (moreAfter) begin
          nextIdx   = nibIdx + 2'd1;
          nextState = ADDR;
        end else begin
          nextState = IDLE;
        end
      end
      DGAP: begin
        if (gapCnt != 3'd0) begin
          nextGap = gapCnt - 3'd1;
        end else if (moreAfter) begin
          nextIdx   = nibIdx + 2'd1;
          nextState = ADDR;
        end else begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      nibIdx <= 2'd0;
      gapCnt <= 3'd0;
      curCmd <= '0;
    end else begin
      state  <= nextState;
      nibIdx <= nextIdx;
      gapCnt <= nextGap;
      if (loadCmd)
        curCmd <= popEntry;
    end
  end

  // Bus outputs trail the FSM state by one cycle so they come straight from flops.
  always_ff @(posedge CLK) begin
    if (RST) begin
      A0  <= 1'b0;
      WR  <= 1'b0;
      D   <= 4'd0;
      err <= 1'b0;
    end else begin
      err <= cmdAccept && cmdInvalid;
      WR  <= ((state == ADDR) && found) || (state == DATA);
      A0  <= (state == DATA);
      if ((state == ADDR) && found)
        D <= addrOf(curCmd, effIdx);
      else if (state == DATA)
        D <= nibbleOf(curCmd, nibIdx);
      else
        D <= 4'd0;
    end
  end

endmodule
